tdc_stream_arbiter: RTL and testbench

//  Round-robin arbiter sharing one Ethernet packet builder among N_SRC TDC readout FIFOs (FWFT).

---
 rtl/tdc_stream_arbiter.sv | 131 +++++++++++++
 tb/tb_tdc_stream_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_stream_arbiter.sv
// Round-robin arbiter sharing one Ethernet packet builder among N_SRC FWFT TDC FIFOs.
// The granted FIFO is muxed through with zero latency; the grant is held for a whole
// frame and dropped on the builder's last-byte pulse or when no read arrives in time.
module tdc_stream_arbiter #(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned DATA_W        = 40,
  parameter int unsigned GRANT_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [N_SRC-1:0]        src_mask,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_ready,
  output logic [N_SRC-1:0]        src_rd,
  output logic [DATA_W-1:0]       pkt_data,
  output logic                    pkt_ready,
  input  logic                    pkt_rd,
  input  logic                    pkt_last,
  output logic                    grant_valid,
  output logic [ID_W-1:0]         grant_id,
  output logic [15:0]             word_cnt,
  output logic                    rd_err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO_W = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_SRC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [TMO_W-1:0]  tmo;

  logic [N_SRC-1:0]  req;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   pick_idx;
  logic              no_rd_yet;
  logic [DATA_W-1:0] src_word [N_SRC];

  // Slice the flat head-word bus into one word per source
  for (genvar g = 0; g < N_SRC; g++) begin : g_word
    assign src_word[g] = src_data[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: lowest offset from rr_ptr among requesting, unmasked sources
  always_comb begin
    req        = src_ready & src_mask;
    pick_found = 1'b0;
    pick_id    = '0;
    pick_idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      pick_idx = ID_W'((int'(rr_ptr) + k) % N_SRC);
      if (req[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = pick_idx;
      end
    end
  end

  assign no_rd_yet = (word_cnt == '0) && !pkt_rd;

  // Zero-latency pass-through of the granted FIFO; everything idle outside GRANT
  always_comb begin
    src_rd    = '0;
    pkt_ready = 1'b0;
    pkt_data  = '0;
    if (state == ST_GRANT) begin
      pkt_data         = src_word[grant_id];
      pkt_ready        = src_ready[grant_id];
      src_rd[grant_id] = pkt_rd;
    end
  end

  // Arbitration FSM with grant bookkeeping, word counter, timeout and read-error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ARB;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      word_cnt    <= '0;
      rd_err      <= 1'b0;
      tmo         <= '0;
    end else begin
      if (pkt_rd && (state != ST_GRANT)) begin
        rd_err <= 1'b1;
      end
      case (state)
        ST_ARB: begin
          if (enable && pick_found) begin
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            word_cnt    <= '0;
            tmo         <= '0;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (pkt_rd && (word_cnt != CNT_MAX)) begin
            word_cnt <= word_cnt + CNT_W'(1);
          end
          if (no_rd_yet) begin
            tmo <= tmo + TMO_W'(1);
          end
          if (pkt_last || (no_rd_yet && (tmo == TMO_LAST))) begin
            grant_valid <= 1'b0;
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          rr_ptr <= (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
          state  <= ST_ARB;
        end
        default: begin
          state <= ST_ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_stream_arbiter.sv
// Bench for tdc_stream_arbiter: cycle vector table, directed multi-cycle sequences,
// and a randomized run compared against a frame-level reference model.
module tb_tdc_stream_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 40;
  localparam int unsigned TMO = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    src_mask = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_ready = '0;
  logic [N-1:0]    src_rd;
  logic [DW-1:0]   pkt_data;
  logic            pkt_ready;
  logic            pkt_rd = 1'b0;
  logic            pkt_last = 1'b0;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic [15:0]     word_cnt;
  logic            rd_err;

  int n_chk  = 0;
  int n_pass = 0;

  tdc_stream_arbiter #(
    .N_SRC(N), .ID_W(2), .DATA_W(DW), .GRANT_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .src_mask(src_mask),
    .src_data(src_data), .src_ready(src_ready), .src_rd(src_rd),
    .pkt_data(pkt_data), .pkt_ready(pkt_ready), .pkt_rd(pkt_rd),
    .pkt_last(pkt_last), .grant_valid(grant_valid), .grant_id(grant_id),
    .word_cnt(word_cnt), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return DW'(src_data >> (i * DW));
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    src_mask  = '0;
    src_ready = '0;
    pkt_rd    = 1'b0;
    pkt_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Vector: inputs for one cycle and outputs expected while that cycle is current
  typedef struct {
    logic [3:0]  ready;
    logic [3:0]  mask;
    logic        en;
    logic        rd;
    logic        last;
    logic [3:0]  x_src_rd;
    logic        x_pkt_ready;
    logic        x_in_grant;
    logic        x_gv;
    logic [1:0]  x_gid;
    logic [15:0] x_wc;
    logic        x_err;
  } vec_t;

  vec_t tbl [20];

  // Reference model state (frame level)
  bit m_busy, m_gap, m_err;
  int m_gid, m_next, m_words, m_idle;

  task automatic model_step();
    logic [N-1:0] req;
    req = src_ready & src_mask;
    if (pkt_rd && !m_busy) m_err = 1'b1;
    if (m_busy) begin
      if (pkt_rd) m_words = (m_words < 65535) ? m_words + 1 : 65535;
      else if (m_words == 0) m_idle++;
      if (pkt_last || (m_idle == TMO)) begin
        m_busy = 1'b0;
        m_gap  = 1'b1;
      end
    end else if (m_gap) begin
      m_next = (m_gid + 1) % N;
      m_gap  = 1'b0;
    end else if (enable && (req != 0)) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_next + k) % N]) begin
          m_gid = (m_next + k) % N;
          break;
        end
      end
      m_busy  = 1'b1;
      m_words = 0;
      m_idle  = 0;
    end
  endtask

  initial begin
    int lows;
    int hi;
    logic [3:0]  e_rd;
    logic        e_rdy;
    logic [DW-1:0] e_data;

    //                ready    mask  en    rd    last  src_rd  prdy  ingr  gv    gid   wc     err
    tbl[0]  = '{4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0};
    tbl[1]  = '{4'b0001, 4'hF, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 16'd0, 1'b0};
    tbl[2]  = '{4'b0001, 4'hF, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 16'd1, 1'b0};
    tbl[3]  = '{4'b0001, 4'hF, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 16'd2, 1'b0};
    tbl[4]  = '{4'b1111, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3, 1'b0};
    tbl[5]  = '{4'b1111, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'd3, 1'b0};
    tbl[6]  = '{4'b1111, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 16'd0, 1'b0};
    tbl[7]  = '{4'b1010, 4'h2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 16'd0, 1'b0};
    tbl[8]  = '{4'b1010, 4'h2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 16'd0, 1'b0};
    tbl[9]  = '{4'b1010, 4'h2, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 16'd0, 1'b0};
    tbl[10] = '{4'b1000, 4'h2, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 16'd1, 1'b0};
    tbl[11] = '{4'b1010, 4'h2, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 16'd2, 1'b0};
    tbl[12] = '{4'b0000, 4'h2, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 16'd2, 1'b1};
    tbl[13] = '{4'b1000, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 16'd2, 1'b1};
    tbl[14] = '{4'b1000, 4'hF, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 16'd2, 1'b1};
    tbl[15] = '{4'b1000, 4'h0, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 2'd3, 16'd0, 1'b1};
    tbl[16] = '{4'b1000, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 16'd1, 1'b1};
    tbl[17] = '{4'b1111, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'd1, 1'b1};
    tbl[18] = '{4'b1111, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'd1, 1'b1};
    tbl[19] = '{4'b1111, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 16'd1, 1'b1};

    src_data = {40'h33_DEAD_0003, 40'h22_BEEF_0002, 40'h11_CAFE_0001, 40'h00_F00D_0000};

    // Reset state
    do_reset();
    chk("reset grant_valid", grant_valid, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset word_cnt", word_cnt, 0);
    chk("reset rd_err", rd_err, 0);
    chk("reset src_rd", src_rd, 0);
    chk("reset pkt_ready", pkt_ready, 0);

    // Vector table
    for (int i = 0; i < 20; i++) begin
      src_ready = tbl[i].ready;
      src_mask  = tbl[i].mask;
      enable    = tbl[i].en;
      pkt_rd    = tbl[i].rd;
      pkt_last  = tbl[i].last;
      @(negedge clk);
      chk($sformatf("vec%0d src_rd", i), src_rd, tbl[i].x_src_rd);
      chk($sformatf("vec%0d pkt_ready", i), pkt_ready, tbl[i].x_pkt_ready);
      chk($sformatf("vec%0d pkt_data", i), pkt_data,
          tbl[i].x_in_grant ? word_of(int'(tbl[i].x_gid)) : '0);
      chk($sformatf("vec%0d grant_valid", i), grant_valid, tbl[i].x_gv);
      chk($sformatf("vec%0d grant_id", i), grant_id, tbl[i].x_gid);
      chk($sformatf("vec%0d word_cnt", i), word_cnt, tbl[i].x_wc);
      chk($sformatf("vec%0d rd_err", i), rd_err, tbl[i].x_err);
      @(posedge clk);
      #1;
    end

    // 20-word frame from source 0
    do_reset();
    src_ready = 4'b0001; src_mask = 4'hF; enable = 1'b1;
    @(posedge clk); #1;
    chk("f20 grant_valid", grant_valid, 1);
    chk("f20 grant_id", grant_id, 0);
    pkt_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) pkt_last = 1'b1;
      #1 chk($sformatf("f20 src_rd%0d", i), src_rd, 4'b0001);
      @(posedge clk); #1;
    end
    pkt_rd = 1'b0; pkt_last = 1'b0;
    chk("f20 released", grant_valid, 0);
    chk("f20 word_cnt", word_cnt, 20);

    // Round-robin order with all sources ready, 2-cycle gap between frames
    do_reset();
    src_ready = 4'hF; src_mask = 4'hF; enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      lows = 0;
      while (!grant_valid && lows < 8) begin
        @(posedge clk); #1;
        lows++;
      end
      chk($sformatf("rr%0d grant_valid", f), grant_valid, 1);
      if (f > 0) chk($sformatf("rr%0d gap", f), lows, 2);
      chk($sformatf("rr%0d grant_id", f), grant_id, f % N);
      pkt_last = 1'b1;
      @(posedge clk); #1;
      pkt_last = 1'b0;
    end

    // Timeout with no pkt_rd, then rr_ptr advance
    do_reset();
    src_ready = 4'b0100; src_mask = 4'hF; enable = 1'b1;
    lows = 0;
    while (!grant_valid && lows < 8) begin
      @(posedge clk); #1;
      lows++;
    end
    chk("tmo grant_id", grant_id, 2);
    src_ready = 4'b0000;
    hi = 0;
    while (grant_valid && hi < 2000) begin
      hi++;
      @(posedge clk); #1;
    end
    chk("tmo grant length", hi, TMO);
    chk("tmo word_cnt", word_cnt, 0);
    src_ready = 4'hF;
    lows = 0;
    while (!grant_valid && lows < 8) begin
      @(posedge clk); #1;
      lows++;
    end
    chk("tmo next grant_id", grant_id, 3);

    // Async reset in the middle of a grant
    pkt_rd = 1'b1;
    #1 chk("mid src_rd before reset", src_rd, 4'b1000);
    #1 rst_n = 1'b0;
    #1;
    chk("mid reset src_rd", src_rd, 0);
    chk("mid reset pkt_ready", pkt_ready, 0);
    chk("mid reset pkt_data", pkt_data, 0);
    chk("mid reset grant_valid", grant_valid, 0);
    chk("mid reset word_cnt", word_cnt, 0);
    chk("mid reset rd_err", rd_err, 0);
    pkt_rd = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized run against the reference model
    do_reset();
    m_busy = 0; m_gap = 0; m_err = 0;
    m_gid = 0; m_next = 0; m_words = 0; m_idle = 0;
    for (int c = 0; c < 3000; c++) begin
      src_ready = 4'($urandom);
      src_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      enable    = ($urandom_range(0, 7) != 0);
      src_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      pkt_rd    = m_busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 63) == 0);
      pkt_last  = m_busy && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      e_rd   = (m_busy && pkt_rd) ? 4'(1 << m_gid) : 4'd0;
      e_rdy  = m_busy ? 1'(src_ready >> m_gid) : 1'b0;
      e_data = m_busy ? word_of(m_gid) : '0;
      chk($sformatf("rnd%0d src_rd", c), src_rd, e_rd);
      chk($sformatf("rnd%0d pkt_ready", c), pkt_ready, e_rdy);
      chk($sformatf("rnd%0d pkt_data", c), pkt_data, e_data);
      chk($sformatf("rnd%0d grant_valid", c), grant_valid, m_busy);
      if (m_busy) chk($sformatf("rnd%0d grant_id", c), grant_id, m_gid);
      chk($sformatf("rnd%0d word_cnt", c), word_cnt, m_words);
      chk($sformatf("rnd%0d rd_err", c), rd_err, m_err);
      model_step();
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
